// File: rtl/instruction_memory_loader.sv
// Streams bytes over valid/ready, packs them big-endian into 32-bit words and
// writes them to the instruction memory while holding the CPU.
module instruction_memory_loader #(
   parameter int MEMORY_WIDTH = 32,
   parameter int MEMORY_DEPTH = 50,
   parameter int LENGTH_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    IL_Start,
   input  logic [LENGTH_WIDTH-1:0] IL_Length,
   input  logic [7:0]              IL_Byte_In,
   input  logic                    IL_Byte_Valid,
   output logic                    IL_Byte_Ready,
   output logic                    IL_Write_Enable,
   output logic [31:0]             IL_Write_Address,
   output logic [MEMORY_WIDTH-1:0] IL_Write_Data,
   output logic                    IL_CPU_Hold,
   output logic                    IL_Done,
   output logic                    IL_Error,
   output logic [LENGTH_WIDTH-1:0] IL_Words_Written,
   output logic [7:0]              IL_Checksum
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t                  state_r;
   state_t                  state_next_s;
   logic [LENGTH_WIDTH-1:0] length_r;
   logic [LENGTH_WIDTH-1:0] words_r;
   logic [1:0]              byte_cnt_r;
   logic [MEMORY_WIDTH-1:0] word_r;
   logic [MEMORY_WIDTH-1:0] assembled_s;
   logic [MEMORY_WIDTH-1:0] data_r;
   logic [31:0]             addr_r;
   logic [7:0]              checksum_r;
   logic                    ready_r;
   logic                    we_r;
   logic                    hold_r;
   logic                    done_r;
   logic                    error_r;
   logic                    start_acc_s;
   logic                    accept_s;
   logic                    last_word_s;
   logic                    len_zero_s;
   logic                    len_big_s;

   // Handshake and length qualifiers
   always_comb begin
      start_acc_s = IL_Start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERROR));
      accept_s    = (state_r == S_RECV) && IL_Byte_Valid;
      last_word_s = ((words_r + {{(LENGTH_WIDTH-1){1'b0}}, 1'b1}) == length_r);
      len_zero_s  = (IL_Length == {LENGTH_WIDTH{1'b0}});
      len_big_s   = (IL_Length > LENGTH_WIDTH'(MEMORY_DEPTH));
   end

   // Byte lane insert: first byte lands in the most significant lane
   always_comb begin
      assembled_s = word_r;
      case (byte_cnt_r)
         2'd0:    assembled_s[31:24] = IL_Byte_In;
         2'd1:    assembled_s[23:16] = IL_Byte_In;
         2'd2:    assembled_s[15:8]  = IL_Byte_In;
         2'd3:    assembled_s[7:0]   = IL_Byte_In;
         default: assembled_s        = word_r;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_acc_s) begin
               if (len_zero_s) begin
                  state_next_s = S_DONE;
               end else if (len_big_s) begin
                  state_next_s = S_ERROR;
               end else begin
                  state_next_s = S_RECV;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         S_RECV: begin
            if (accept_s && (byte_cnt_r == 2'd3)) begin
               state_next_s = S_WRITE;
            end else begin
               state_next_s = S_RECV;
            end
         end
         S_WRITE: begin
            if (last_word_s) begin
               state_next_s = S_DONE;
            end else begin
               state_next_s = S_RECV;
            end
         end
         default: state_next_s = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Datapath and status registers; strobes are registered from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         length_r   <= {LENGTH_WIDTH{1'b0}};
         words_r    <= {LENGTH_WIDTH{1'b0}};
         byte_cnt_r <= 2'd0;
         word_r     <= {MEMORY_WIDTH{1'b0}};
         data_r     <= {MEMORY_WIDTH{1'b0}};
         addr_r     <= 32'd0;
         checksum_r <= 8'd0;
         ready_r    <= 1'b0;
         we_r       <= 1'b0;
         hold_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         ready_r <= (state_next_s == S_RECV);
         we_r    <= (state_next_s == S_WRITE);
         hold_r  <= (state_next_s == S_RECV) || (state_next_s == S_WRITE);
         if (start_acc_s) begin
            length_r   <= IL_Length;
            words_r    <= {LENGTH_WIDTH{1'b0}};
            byte_cnt_r <= 2'd0;
            checksum_r <= 8'd0;
            done_r     <= len_zero_s;
            error_r    <= len_big_s && !len_zero_s;
         end else if (accept_s) begin
            checksum_r <= checksum_r + IL_Byte_In;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            word_r     <= assembled_s;
            if (byte_cnt_r == 2'd3) begin
               addr_r <= 32'(words_r);
               data_r <= assembled_s;
            end
         end else if (state_r == S_WRITE) begin
            words_r    <= words_r + {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};
            byte_cnt_r <= 2'd0;
            done_r     <= last_word_s;
         end
      end
   end

   assign IL_Byte_Ready    = ready_r;
   assign IL_Write_Enable  = we_r;
   assign IL_Write_Address = addr_r;
   assign IL_Write_Data    = data_r;
   assign IL_CPU_Hold      = hold_r;
   assign IL_Done          = done_r;
   assign IL_Error         = error_r;
   assign IL_Words_Written = words_r;
   assign IL_Checksum      = checksum_r;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader; writes are checked against a
// scoreboard queue filled as each word's bytes are driven.
module tb_instruction_memory_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        IL_Start;
   logic [15:0] IL_Length;
   logic [7:0]  IL_Byte_In;
   logic        IL_Byte_Valid;
   logic        IL_Byte_Ready;
   logic        IL_Write_Enable;
   logic [31:0] IL_Write_Address;
   logic [31:0] IL_Write_Data;
   logic        IL_CPU_Hold;
   logic        IL_Done;
   logic        IL_Error;
   logic [15:0] IL_Words_Written;
   logic [7:0]  IL_Checksum;

   int          tests = 0;
   int          fails = 0;
   int          wr_count = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  sum;

   instruction_memory_loader dut (
      .clk(clk), .reset(reset), .IL_Start(IL_Start), .IL_Length(IL_Length),
      .IL_Byte_In(IL_Byte_In), .IL_Byte_Valid(IL_Byte_Valid),
      .IL_Byte_Ready(IL_Byte_Ready), .IL_Write_Enable(IL_Write_Enable),
      .IL_Write_Address(IL_Write_Address), .IL_Write_Data(IL_Write_Data),
      .IL_CPU_Hold(IL_CPU_Hold), .IL_Done(IL_Done), .IL_Error(IL_Error),
      .IL_Words_Written(IL_Words_Written), .IL_Checksum(IL_Checksum)
   );

   always #5 clk = ~clk;

   task automatic check(input logic [63:0] obs, input logic [63:0] expv, input string tag);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every write strobe pops one expected {address, data}
   always @(negedge clk) begin
      if (IL_Write_Enable) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            check(64'd1, 64'd0, "unexpected_write");
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check({32'd0, IL_Write_Address}, {32'd0, e[63:32]}, "write_addr");
            check({32'd0, IL_Write_Data}, {32'd0, e[31:0]}, "write_data");
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      IL_Byte_In    = b;
      IL_Byte_Valid = 1'b1;
      n = 0;
      while (!IL_Byte_Ready && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) check(64'd0, 64'd1, "byte_timeout");
      step();
      sum = sum + b;
   endtask

   task automatic start(input logic [15:0] len);
      IL_Start  = 1'b1;
      IL_Length = len;
      step();
      IL_Start  = 1'b0;
      IL_Length = 16'hFFFF;
      sum = 8'd0;
   endtask

   // Sends one word; the write strobe must appear right after the fourth byte
   task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
      exp_q.push_back({addr, w});
      for (int i = 0; i < 4; i++) begin
         logic [31:0] t;
         t = w;
         send_byte(t[31-8*i -: 8]);
      end
      IL_Byte_Valid = 1'b0;
      check({63'd0, IL_Write_Enable}, 64'd1, "we_after_4th");
      check({63'd0, IL_Byte_Ready}, 64'd0, "ready_in_write");
      check({63'd0, IL_CPU_Hold}, 64'd1, "hold_in_write");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({63'd0, IL_Byte_Ready}, 64'd0, {tag, "_ready"});
      check({63'd0, IL_Write_Enable}, 64'd0, {tag, "_we"});
      check({32'd0, IL_Write_Address}, 64'd0, {tag, "_addr"});
      check({32'd0, IL_Write_Data}, 64'd0, {tag, "_data"});
      check({63'd0, IL_CPU_Hold}, 64'd0, {tag, "_hold"});
      check({62'd0, IL_Done, IL_Error}, 64'd0, {tag, "_done_err"});
      check({48'd0, IL_Words_Written}, 64'd0, {tag, "_words"});
      check({56'd0, IL_Checksum}, 64'd0, {tag, "_csum"});
   endtask

   initial begin
      int wc;
      reset = 1'b1; IL_Start = 1'b0; IL_Length = 16'd0;
      IL_Byte_In = 8'd0; IL_Byte_Valid = 1'b0; sum = 8'd0;
      step(); step();
      reset = 1'b0;
      check_reset_outputs("reset");

      // Two-word load at full rate
      start(16'd2);
      check({63'd0, IL_Byte_Ready}, 64'd1, "ready_recv");
      check({63'd0, IL_CPU_Hold}, 64'd1, "hold_recv");
      send_word(32'd0, 32'h20080005);
      send_word(32'd1, 32'h01095020);
      step();
      check({63'd0, IL_Done}, 64'd1, "done1");
      check({48'd0, IL_Words_Written}, 64'd2, "words1");
      check({56'd0, IL_Checksum}, {56'd0, sum}, "csum1");
      check({56'd0, IL_Checksum}, 64'hA7, "csum1_const");
      check({63'd0, IL_CPU_Hold}, 64'd0, "hold_done1");

      // Valid gap between bytes 2 and 3
      start(16'd2);
      exp_q.push_back({32'd0, 32'h20080005});
      send_byte(8'h20); send_byte(8'h08);
      IL_Byte_Valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check({63'd0, IL_Write_Enable}, 64'd0, "no_we_in_gap");
      end
      send_byte(8'h00); send_byte(8'h05);
      IL_Byte_Valid = 1'b0;
      check({63'd0, IL_Write_Enable}, 64'd1, "we_after_gap");
      check({63'd0, IL_Byte_Ready}, 64'd0, "ready_write_gap");
      send_word(32'd1, 32'h01095020);
      step();
      check({63'd0, IL_Done}, 64'd1, "done2");
      check({48'd0, IL_Words_Written}, 64'd2, "words2");

      // Length beyond depth
      wc = wr_count;
      start(16'd51);
      check({63'd0, IL_Error}, 64'd1, "err_len51");
      check({63'd0, IL_Done}, 64'd0, "done_len51");
      check({63'd0, IL_CPU_Hold}, 64'd0, "hold_len51");
      step(); step();
      check(64'(wr_count), 64'(wc), "no_write_len51");

      // Zero length, then a single-word load from DONE
      start(16'd0);
      check({63'd0, IL_Done}, 64'd1, "done_len0");
      check({63'd0, IL_Error}, 64'd0, "err_len0");
      check({48'd0, IL_Words_Written}, 64'd0, "words_len0");
      step();
      check(64'(wr_count), 64'(wc), "no_write_len0");
      start(16'd1);
      check({63'd0, IL_Done}, 64'd0, "done_clear_recv");
      send_word(32'd0, 32'hDEADBEEF);
      step();
      check({63'd0, IL_Done}, 64'd1, "done_len1");
      check({48'd0, IL_Words_Written}, 64'd1, "words_len1");
      check({56'd0, IL_Checksum}, {56'd0, sum}, "csum_len1");

      // Reset in the middle of word 1 of a three-word load
      start(16'd3);
      send_word(32'd0, 32'h11223344);
      send_byte(8'h55); send_byte(8'h66);
      IL_Byte_Valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_outputs("midreset");
      start(16'd1);
      send_word(32'd0, 32'hA5A55A5A);
      step();
      check({63'd0, IL_Done}, 64'd1, "done_restart");

      // Start pulse during RECV is ignored
      wc = wr_count;
      start(16'd2);
      exp_q.push_back({32'd0, 32'hCAFEF00D});
      send_byte(8'hCA);
      IL_Start = 1'b1; IL_Length = 16'd5;
      send_byte(8'hFE);
      IL_Start = 1'b0;
      send_byte(8'hF0); send_byte(8'h0D);
      IL_Byte_Valid = 1'b0;
      send_word(32'd1, 32'h0BADC0DE);
      step();
      check({63'd0, IL_Done}, 64'd1, "done_ignore");
      check({48'd0, IL_Words_Written}, 64'd2, "words_ignore");
      check(64'(wr_count - wc), 64'd2, "writes_ignore");
      check(64'(exp_q.size()), 64'd0, "queue_empty");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
